fb_port_arbiter: RTL and testbench

- Shares one single-port synchronous frame-buffer RAM between three users: VGA scan-out, a pixel writer and a random-access reader (for example, an image-processing engine).
- VGA scan-out has absolute priority: one word fetch per 8 pixels during active display.
- All other cycles go round-robin to the writer and the reader.
- Sits between the VGA timing generator, the processing engines and the RAM. It replaces the fixed ROM read path with a shared frame buffer.

---
 rtl/fb_port_arbiter_if.sv | 40 ++++
 rtl/fb_port_arbiter.sv | 69 ++++++
 tb/tb_fb_port_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_port_arbiter_if.sv
// fb_port_arbiter_if: VGA, writer, reader and RAM signals of the frame-buffer arbiter.
// FB_ARB_STATS_EN adds the stall-counter signals.
interface fb_port_arbiter_if #(parameter int ADDR_W = 16, parameter int DATA_W = 8, parameter int PIX_W = 3);
  logic vga_active;
  logic [ADDR_W+PIX_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_word;
  logic vga_word_valid;
  logic wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic wr_ack;
  logic rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic rd_ack;
  logic [DATA_W-1:0] rd_data;
  logic rd_valid;
  logic [ADDR_W-1:0] ram_addr;
  logic ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_q;
`ifdef FB_ARB_STATS_EN
  logic stats_clr;
  logic [15:0] wr_stall_cnt;
  logic [15:0] rd_stall_cnt;
`endif
  modport slave (
    input vga_active, vga_addr, wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_q,
    output vga_word, vga_word_valid, wr_ack, rd_ack, rd_data, rd_valid, ram_addr, ram_we, ram_wdata
`ifdef FB_ARB_STATS_EN
    , input stats_clr, output wr_stall_cnt, rd_stall_cnt
`endif
  );
  modport master (
    output vga_active, vga_addr, wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_q,
    input vga_word, vga_word_valid, wr_ack, rd_ack, rd_data, rd_valid, ram_addr, ram_we, ram_wdata
`ifdef FB_ARB_STATS_EN
    , output stats_clr, input wr_stall_cnt, rd_stall_cnt
`endif
  );
endinterface

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares one frame-buffer RAM between VGA scan-out (priority), a writer and a reader.
// FB_ARB_STATS_EN adds saturating per-client stall counters with a synchronous clear.
module fb_port_arbiter #(parameter int ADDR_W = 16, parameter int DATA_W = 8, parameter int PIX_W = 3) (
  input logic vga_clk,
  input logic rstn,
  fb_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, VGA, WR, RD} owner_t;
  owner_t owner, owner_nx, tag;
  logic ptr_rd, ptr_rd_nx;
  logic vga_slot, wr_el, rd_el;
  logic [ADDR_W-1:0] ram_addr_nx;
  assign vga_slot = bus.vga_active && bus.vga_addr[PIX_W-1:0] == '0;
  // A client whose ack is high this cycle is still holding its old request.
  assign wr_el = bus.wr_req && owner != WR;
  assign rd_el = bus.rd_req && owner != RD;
  assign bus.ram_we = owner == WR;
  assign bus.wr_ack = owner == WR;
  assign bus.rd_ack = owner == RD;
  always_comb begin
    owner_nx = vga_slot ? VGA : (wr_el && rd_el) ? (ptr_rd ? RD : WR) : wr_el ? WR : rd_el ? RD : IDLE;
    ptr_rd_nx = owner_nx == WR ? 1'b1 : owner_nx == RD ? 1'b0 : ptr_rd;
    ram_addr_nx = owner_nx == VGA ? bus.vga_addr[ADDR_W+PIX_W-1:PIX_W] :
                  owner_nx == WR ? bus.wr_addr : owner_nx == RD ? bus.rd_addr : bus.ram_addr;
  end
  always_ff @(posedge vga_clk) begin
    if (!rstn) begin
      owner <= IDLE;
      ptr_rd <= 1'b0;
    end else begin
      owner <= owner_nx;
      ptr_rd <= ptr_rd_nx;
    end
  end
  // tag follows the RAM's one-cycle read latency so returning data is steered to its requester.
  always_ff @(posedge vga_clk) begin
    if (!rstn) begin
      tag <= IDLE;
      bus.ram_addr <= '0;
      bus.ram_wdata <= '0;
      bus.rd_data <= '0;
      bus.rd_valid <= 1'b0;
      bus.vga_word <= '0;
      bus.vga_word_valid <= 1'b0;
    end else begin
      tag <= owner;
      bus.ram_addr <= ram_addr_nx;
      if (owner_nx == WR) bus.ram_wdata <= bus.wr_data;
      bus.rd_valid <= tag == RD;
      bus.vga_word_valid <= tag == VGA;
      if (tag == RD) bus.rd_data <= bus.ram_q;
      if (tag == VGA) bus.vga_word <= bus.ram_q;
    end
  end
`ifdef FB_ARB_STATS_EN
  logic wr_stall, rd_stall;
  assign wr_stall = wr_el && owner_nx != WR;
  assign rd_stall = rd_el && owner_nx != RD;
  always_ff @(posedge vga_clk) begin
    if (!rstn || bus.stats_clr) begin
      bus.wr_stall_cnt <= '0;
      bus.rd_stall_cnt <= '0;
    end else begin
      bus.wr_stall_cnt <= bus.wr_stall_cnt + 16'(wr_stall && !(&bus.wr_stall_cnt));
      bus.rd_stall_cnt <= bus.rd_stall_cnt + 16'(rd_stall && !(&bus.rd_stall_cnt));
    end
  end
`endif
endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: directed tests of the frame-buffer arbiter against a registered-read RAM model.
module tb_fb_port_arbiter;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] mem [0:65535];
  fb_port_arbiter_if bus ();
  fb_port_arbiter dut (.vga_clk(clk), .rstn(rstn), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_q <= mem[bus.ram_addr];
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_inputs();
    bus.vga_active = 1'b0;
    bus.vga_addr = '0;
    bus.wr_req = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_req = 1'b0;
    bus.rd_addr = '0;
`ifdef FB_ARB_STATS_EN
    bus.stats_clr = 1'b0;
`endif
  endtask
  task automatic do_reset();
    clear_inputs();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask
  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({bus.vga_word, bus.vga_word_valid, bus.wr_ack, bus.rd_ack, bus.rd_data, bus.rd_valid,
         bus.ram_addr, bus.ram_we, bus.ram_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ram_addr=%h we=%b acks=%b%b valids=%b%b, required all zero",
               bus.ram_addr, bus.ram_we, bus.wr_ack, bus.rd_ack, bus.rd_valid, bus.vga_word_valid);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      n_chk++;
      if ({bus.ram_we, bus.wr_ack, bus.rd_ack, bus.rd_valid, bus.vga_word_valid, bus.ram_addr} !== '0) begin
        n_fail++;
        $display("FAIL idle_cycle%0d: we=%b acks=%b%b valids=%b%b addr=%h, required all zero",
                 i, bus.ram_we, bus.wr_ack, bus.rd_ack, bus.rd_valid, bus.vga_word_valid, bus.ram_addr);
      end
    end
  endtask
  task automatic test_blank_write();
    bus.wr_req = 1'b1;
    bus.wr_addr = 16'h0010;
    bus.wr_data = 8'hA5;
    step();
    n_chk++;
    if ({bus.wr_ack, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.rd_ack} !== {1'b1, 1'b1, 16'h0010, 8'hA5, 1'b0}) begin
      n_fail++;
      $display("FAIL blank_write: ack=%b we=%b addr=%h wdata=%h rd_ack=%b, required 1 1 0010 a5 0",
               bus.wr_ack, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.rd_ack);
    end
    bus.wr_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++;
      if ({bus.wr_ack, bus.ram_we} !== 2'b00) begin
        n_fail++;
        $display("FAIL single_write%0d: ack=%b we=%b, required 0 0", i, bus.wr_ack, bus.ram_we);
      end
    end
  endtask
  task automatic test_read_after_write();
    bus.rd_req = 1'b1;
    bus.rd_addr = 16'h0010;
    step();
    n_chk++;
    if ({bus.rd_ack, bus.ram_we, bus.ram_addr, bus.rd_valid} !== {1'b1, 1'b0, 16'h0010, 1'b0}) begin
      n_fail++;
      $display("FAIL read_issue: ack=%b we=%b addr=%h valid=%b, required 1 0 0010 0",
               bus.rd_ack, bus.ram_we, bus.ram_addr, bus.rd_valid);
    end
    bus.rd_req = 1'b0;
    step();
    n_chk++;
    if ({bus.rd_ack, bus.rd_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL read_c1: ack=%b valid=%b, required 0 0", bus.rd_ack, bus.rd_valid);
    end
    step();
    n_chk++;
    if ({bus.rd_valid, bus.rd_data, bus.vga_word_valid} !== {1'b1, 8'hA5, 1'b0}) begin
      n_fail++;
      $display("FAIL read_c2: valid=%b data=%h vga_valid=%b, required 1 a5 0",
               bus.rd_valid, bus.rd_data, bus.vga_word_valid);
    end
    step();
    n_chk++;
    if ({bus.rd_valid, bus.rd_data} !== {1'b0, 8'hA5}) begin
      n_fail++;
      $display("FAIL read_hold: valid=%b data=%h, required 0 a5", bus.rd_valid, bus.rd_data);
    end
  endtask
  task automatic test_vga_priority();
    do_reset();
    bus.vga_active = 1'b1;
    bus.vga_addr = 19'h00080;
    bus.wr_req = 1'b1;
    bus.wr_addr = 16'h0020;
    bus.wr_data = 8'h3C;
    bus.rd_req = 1'b1;
    bus.rd_addr = 16'h0030;
    step();
    n_chk++;
    if ({bus.ram_addr, bus.ram_we, bus.wr_ack, bus.rd_ack} !== {16'h0010, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL vga_slot: addr=%h we=%b acks=%b%b, required 0010 0 00",
               bus.ram_addr, bus.ram_we, bus.wr_ack, bus.rd_ack);
    end
    for (int k = 1; k <= 7; k++) begin
      bus.vga_addr = 19'h00080 + 19'(k);
      step();
      n_chk++;
      if ({bus.wr_ack, bus.rd_ack, bus.vga_word_valid} !== {k % 2 == 1, k % 2 == 0, k == 2}) begin
        n_fail++;
        $display("FAIL vga_cycle%0d: wr_ack=%b rd_ack=%b vga_valid=%b, required %b %b %b",
                 k, bus.wr_ack, bus.rd_ack, bus.vga_word_valid, k % 2 == 1, k % 2 == 0, k == 2);
      end
      if (k == 2) begin
        n_chk++;
        if (bus.vga_word !== 8'hA5) begin
          n_fail++;
          $display("FAIL vga_word: got %h, required a5", bus.vga_word);
        end
      end
    end
    clear_inputs();
    step();
  endtask
  task automatic test_vga_fall();
    do_reset();
    bus.vga_active = 1'b1;
    bus.vga_addr = 19'h00080;
    step();
    bus.vga_active = 1'b0;
    step();
    n_chk++;
    if (bus.vga_word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL vga_fall_c1: valid=%b, required 0", bus.vga_word_valid);
    end
    step();
    n_chk++;
    if ({bus.vga_word_valid, bus.vga_word} !== {1'b1, 8'hA5}) begin
      n_fail++;
      $display("FAIL vga_fall_c2: valid=%b word=%h, required 1 a5", bus.vga_word_valid, bus.vga_word);
    end
  endtask
  task automatic test_round_robin();
    do_reset();
    bus.wr_req = 1'b1;
    bus.wr_addr = 16'h0040;
    bus.wr_data = 8'h5A;
    bus.rd_req = 1'b1;
    bus.rd_addr = 16'h0010;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_chk++;
      if ({bus.wr_ack, bus.rd_ack} !== {k % 2 == 1, k % 2 == 0}) begin
        n_fail++;
        $display("FAIL rr_grant%0d: wr_ack=%b rd_ack=%b, required %b %b",
                 k, bus.wr_ack, bus.rd_ack, k % 2 == 1, k % 2 == 0);
      end
    end
    clear_inputs();
    step();
    step();
  endtask
  task automatic test_reset_mid_read();
    bus.rd_req = 1'b1;
    bus.rd_addr = 16'h0010;
    step();
    bus.rd_req = 1'b0;
    step();
    step();
    n_chk++;
    if ({bus.rd_valid, bus.rd_data} !== {1'b1, 8'hA5}) begin
      n_fail++;
      $display("FAIL pre_reset_read: valid=%b data=%h, required 1 a5", bus.rd_valid, bus.rd_data);
    end
    bus.rd_req = 1'b1;
    step();
    n_chk++;
    if (bus.rd_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_read_ack: ack=%b, required 1", bus.rd_ack);
    end
    bus.rd_req = 1'b0;
    step();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    n_chk++;
    if ({bus.rd_valid, bus.rd_data} !== {1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL mid_read_reset: valid=%b data=%h, required 0 00", bus.rd_valid, bus.rd_data);
    end
    step();
    n_chk++;
    if ({bus.rd_valid, bus.rd_data} !== {1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL mid_read_after: valid=%b data=%h, required 0 00", bus.rd_valid, bus.rd_data);
    end
  endtask
`ifdef FB_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    bus.vga_active = 1'b1;
    bus.vga_addr = 19'h00080;
    bus.rd_req = 1'b1;
    for (int i = 0; i < 5; i++) step();
    clear_inputs();
    step();
    n_chk++;
    if ({bus.rd_stall_cnt, bus.wr_stall_cnt} !== {16'd5, 16'd0}) begin
      n_fail++;
      $display("FAIL stall_cnt: rd=%0d wr=%0d, required 5 0", bus.rd_stall_cnt, bus.wr_stall_cnt);
    end
    bus.stats_clr = 1'b1;
    step();
    bus.stats_clr = 1'b0;
    n_chk++;
    if (bus.rd_stall_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL stall_clr: rd=%0d, required 0", bus.rd_stall_cnt);
    end
  endtask
`endif
  initial begin
    clear_inputs();
    test_reset();
    test_blank_write();
    test_read_after_write();
    test_vga_priority();
    test_vga_fall();
    test_round_robin();
    test_reset_mid_read();
`ifdef FB_ARB_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
